lm_sm_sequencer: RTL and testbench



---
 rtl/lm_sm_sequencer_if.sv | 32 +++
 rtl/lm_sm_sequencer.sv | 99 +++++++++
 tb/tb_lm_sm_sequencer.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/lm_sm_sequencer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lm_sm_sequencer_if : controller <-> LM/SM register-list sequencer bundle
// Rev 1.0
// ---------------------------------------------------------------------------
interface lm_sm_sequencer_if #(
   parameter int ADDR_W = 16,
   parameter int LIST_W = 8,
   parameter int IDX_W  = 3
);
   logic              start;
   logic [LIST_W-1:0] reg_list;
   logic [ADDR_W-1:0] base_addr;
   logic              step;
   logic              busy;
   logic [IDX_W-1:0]  reg_addr;
   logic [ADDR_W-1:0] mem_addr;
   logic [IDX_W:0]    count;
   logic              last;
   logic              done;

   modport master (
      output start, reg_list, base_addr, step,
      input  busy, reg_addr, mem_addr, count, last, done
   );

   modport slave (
      input  start, reg_list, base_addr, step,
      output busy, reg_addr, mem_addr, count, last, done
   );
endinterface
`default_nettype wire

// File: rtl/lm_sm_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lm_sm_sequencer : walks an LM/SM register list, one index/address per step.
// Optional macro LMSM_HIGH_FIRST_EN : transfer highest register first.
// Rev 1.0
// ---------------------------------------------------------------------------
module lm_sm_sequencer #(
   parameter int ADDR_W = 16,
   parameter int LIST_W = 8,
   parameter int IDX_W  = 3
) (
   input  wire logic        clk,
   input  wire logic        proc_rst,
   lm_sm_sequencer_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACTIVE = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   state_t            r_state,    w_state_nxt;
   logic [LIST_W-1:0] r_pending,  w_pending_nxt;
   logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
   logic [IDX_W:0]    r_count,    w_count_nxt;

   logic [IDX_W-1:0]  w_idx;
   logic [LIST_W-1:0] w_remaining;
   logic              w_single;

   // Later loop iterations overwrite earlier hits, so scan direction picks the winner.
   always_comb begin
      w_idx = '0;
`ifdef LMSM_HIGH_FIRST_EN
      for (int i = 0; i < LIST_W; i++) begin
         if (r_pending[i]) w_idx = IDX_W'(i);
      end
`else
      for (int i = LIST_W - 1; i >= 0; i--) begin
         if (r_pending[i]) w_idx = IDX_W'(i);
      end
`endif
   end

   assign w_remaining = r_pending & ~(LIST_W'(1) << w_idx);
   assign w_single    = (r_pending != '0) && ((r_pending & (r_pending - LIST_W'(1))) == '0);

   always_comb begin
      w_state_nxt    = r_state;
      w_pending_nxt  = r_pending;
      w_mem_addr_nxt = r_mem_addr;
      w_count_nxt    = r_count;
      case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               w_pending_nxt  = bus.reg_list;
               w_mem_addr_nxt = bus.base_addr;
               w_count_nxt    = '0;
               w_state_nxt    = (bus.reg_list != '0) ? S_ACTIVE : S_DONE;
            end
         end
         S_ACTIVE: begin
            if (bus.step) begin
               w_pending_nxt  = w_remaining;
               w_mem_addr_nxt = r_mem_addr + ADDR_W'(1);
               w_count_nxt    = r_count + (IDX_W+1)'(1);
               if (w_remaining == '0) w_state_nxt = S_DONE;
            end
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Falling-edge update keeps this block in step with the multicycle controller.
   always_ff @(negedge clk) begin
      if (proc_rst) begin
         r_state    <= S_IDLE;
         r_pending  <= '0;
         r_mem_addr <= '0;
         r_count    <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_pending  <= w_pending_nxt;
         r_mem_addr <= w_mem_addr_nxt;
         r_count    <= w_count_nxt;
      end
   end

   assign bus.busy     = (r_state == S_ACTIVE);
   assign bus.done     = (r_state == S_DONE);
   assign bus.last     = (r_state == S_ACTIVE) && w_single;
   assign bus.reg_addr = w_idx;
   assign bus.mem_addr = r_mem_addr;
   assign bus.count    = r_count;

endmodule
`default_nettype wire

// File: tb/tb_lm_sm_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_lm_sm_sequencer : directed self-checking bench for lm_sm_sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_lm_sm_sequencer;

   logic clk;
   logic proc_rst;
   int   n_checks;
   int   n_errors;

   lm_sm_sequencer_if #(.ADDR_W(16), .LIST_W(8), .IDX_W(3)) bus ();

   lm_sm_sequencer #(.ADDR_W(16), .LIST_W(8), .IDX_W(3)) dut (
      .clk      (clk),
      .proc_rst (proc_rst),
      .bus      (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

`ifdef LMSM_HIGH_FIRST_EN
   localparam int BASIC_IDX [4] = '{7, 5, 2, 1};
`else
   localparam int BASIC_IDX [4] = '{1, 2, 5, 7};
`endif

   // n-th register index in transfer order for a given list
   function automatic int nth_reg(input logic [7:0] list, input int n);
      int seen;
      seen = 0;
      for (int j = 0; j < 8; j++) begin
`ifdef LMSM_HIGH_FIRST_EN
         if (list[7-j]) begin
            if (seen == n) return 7 - j;
            seen++;
         end
`else
         if (list[j]) begin
            if (seen == n) return j;
            seen++;
         end
`endif
      end
      return 0;
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick;
      @(negedge clk);
      #1;
   endtask

   initial begin
      n_checks      = 0;
      n_errors      = 0;
      proc_rst      = 1'b1;
      bus.start     = 1'b0;
      bus.step      = 1'b0;
      bus.reg_list  = '0;
      bus.base_addr = '0;
      tick;
      tick;
      proc_rst = 1'b0;

      check_eq("rst_busy",     bus.busy,     0);
      check_eq("rst_done",     bus.done,     0);
      check_eq("rst_last",     bus.last,     0);
      check_eq("rst_reg_addr", bus.reg_addr, 0);
      check_eq("rst_count",    bus.count,    0);
      check_eq("rst_mem_addr", bus.mem_addr, 0);

      // basic order, step every cycle
      bus.reg_list  = 8'b1010_0110;
      bus.base_addr = 16'h0040;
      bus.start     = 1'b1;
      tick;
      bus.start = 1'b0;
      for (int k = 0; k < 4; k++) begin
         check_eq("basic_busy",     bus.busy,     1);
         check_eq("basic_reg_addr", bus.reg_addr, 32'(BASIC_IDX[k]));
         check_eq("basic_mem_addr", bus.mem_addr, 32'(16'h0040 + k));
         check_eq("basic_last",     bus.last,     32'(k == 3));
         check_eq("basic_count",    bus.count,    32'(k));
         check_eq("basic_done",     bus.done,     0);
         bus.step = 1'b1;
         tick;
      end
      bus.step = 1'b0;
      check_eq("basic_done_pulse", bus.done,  1);
      check_eq("basic_done_busy",  bus.busy,  0);
      check_eq("basic_done_count", bus.count, 4);
      tick;
      check_eq("basic_idle_done", bus.done,     0);
      check_eq("basic_idle_addr", bus.mem_addr, 16'h0044);

      // empty list goes straight to done
      bus.reg_list  = 8'h00;
      bus.base_addr = 16'h1234;
      bus.start     = 1'b1;
      tick;
      bus.start = 1'b0;
      check_eq("empty_busy",  bus.busy,  0);
      check_eq("empty_done",  bus.done,  1);
      check_eq("empty_count", bus.count, 0);
      tick;
      check_eq("empty_done_after", bus.done, 0);
      check_eq("empty_busy_after", bus.busy, 0);

      // full list, stall every other cycle, address wrap
      bus.reg_list  = 8'hFF;
      bus.base_addr = 16'hFFFE;
      bus.start     = 1'b1;
      tick;
      bus.start = 1'b0;
      for (int k = 0; k < 8; k++) begin
         check_eq("full_reg_addr", bus.reg_addr, 32'(nth_reg(8'hFF, k)));
         check_eq("full_mem_addr", bus.mem_addr, 32'(16'(16'hFFFE + k)));
         check_eq("full_count",    bus.count,    32'(k));
         check_eq("full_last",     bus.last,     32'(k == 7));
         bus.step = 1'b1;
         tick;
         bus.step = 1'b0;
         if (k < 7) begin
            tick;
            check_eq("full_stall_busy", bus.busy, 1);
         end
      end
      check_eq("full_done",  bus.done,     1);
      check_eq("full_count", bus.count,    8);
      check_eq("full_wrap",  bus.mem_addr, 16'h0006);
      tick;

      // step in IDLE changes nothing
      bus.step = 1'b1;
      tick;
      bus.step = 1'b0;
      check_eq("idle_step_busy",  bus.busy,     0);
      check_eq("idle_step_done",  bus.done,     0);
      check_eq("idle_step_count", bus.count,    8);
      check_eq("idle_step_addr",  bus.mem_addr, 16'h0006);

      // start during ACTIVE is ignored
      bus.reg_list  = 8'h0C;
      bus.base_addr = 16'h0100;
      bus.start     = 1'b1;
      tick;
      check_eq("nostart_reg0", bus.reg_addr, 32'(nth_reg(8'h0C, 0)));
      check_eq("nostart_mem0", bus.mem_addr, 16'h0100);
      bus.reg_list  = 8'hFF;
      bus.base_addr = 16'h0000;
      bus.step      = 1'b1;
      tick;
      bus.step = 1'b0;
      check_eq("nostart_reg1",  bus.reg_addr, 32'(nth_reg(8'h0C, 1)));
      check_eq("nostart_mem1",  bus.mem_addr, 16'h0101);
      check_eq("nostart_last1", bus.last,     1);
      tick;
      check_eq("nostart_hold", bus.reg_addr, 32'(nth_reg(8'h0C, 1)));
      bus.start = 1'b0;
      bus.step  = 1'b1;
      tick;
      bus.step = 1'b0;
      check_eq("nostart_done",  bus.done,  1);
      check_eq("nostart_count", bus.count, 2);
      tick;

      // reset mid-operation
      bus.reg_list  = 8'h0F;
      bus.base_addr = 16'h0020;
      bus.start     = 1'b1;
      tick;
      bus.start = 1'b0;
      bus.step  = 1'b1;
      tick;
      tick;
      bus.step = 1'b0;
      check_eq("midrst_pre_reg",   bus.reg_addr, 32'(nth_reg(8'h0F, 2)));
      check_eq("midrst_pre_count", bus.count,    2);
      proc_rst = 1'b1;
      tick;
      proc_rst = 1'b0;
      check_eq("midrst_busy",  bus.busy,     0);
      check_eq("midrst_count", bus.count,    0);
      check_eq("midrst_mem",   bus.mem_addr, 0);
      check_eq("midrst_reg",   bus.reg_addr, 0);
      check_eq("midrst_done",  bus.done,     0);
      tick;
      check_eq("midrst_no_done", bus.done, 0);

      // fresh start after reset
      bus.reg_list  = 8'h81;
      bus.base_addr = 16'h0010;
      bus.start     = 1'b1;
      tick;
      bus.start = 1'b0;
      check_eq("post_reg0",  bus.reg_addr, 32'(nth_reg(8'h81, 0)));
      check_eq("post_mem0",  bus.mem_addr, 16'h0010);
      check_eq("post_busy",  bus.busy,     1);
      bus.step = 1'b1;
      tick;
      bus.step = 1'b0;
      check_eq("post_reg1",  bus.reg_addr, 32'(nth_reg(8'h81, 1)));
      check_eq("post_mem1",  bus.mem_addr, 16'h0011);
      check_eq("post_last1", bus.last,     1);
      bus.step = 1'b1;
      tick;
      bus.step = 1'b0;
      check_eq("post_done",  bus.done,  1);
      check_eq("post_count", bus.count, 2);
      tick;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
